imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream instruction memory loader with XOR checksum
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int          IDX_W   = $clog2(DEPTH_WORDS + 1);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              core_reset_q, core_reset_d;

    logic              ready;
    logic              fire;
    logic              last_byte;
    logic [31:0]       word;
    logic [IDX_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] addr_calc;

    assign ready     = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign fire      = bus.in_valid && ready;
    assign last_byte = (byte_cnt_q == 2'd3);
    // Bytes arrive LSB first: shift right so byte 0 ends up in [7:0] after four bytes.
    assign word      = {bus.in_data, shift_q[31:8]};
    assign idx_inc   = word_idx_q + IDX_W'(1);

    always_comb begin
        addr_calc = '0;
        addr_calc[IDX_W+1:0] = {word_idx_q, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            count_q      <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        count_d      = count_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        error_d      = error_q;
        core_reset_d = core_reset_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = HDR;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    byte_cnt_d   = '0;
                    word_idx_d   = '0;
                    csum_d       = '0;
                    core_reset_d = 1'b1;
                end
            end
            HDR: begin
                if (fire) begin
                    shift_d    = word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        count_d = word;
                        if ((word == 32'd0) || (word > DEPTH_L)) begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    shift_d    = word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        we_d       = 1'b1;
                        addr_d     = addr_calc;
                        wdata_d    = word;
                        csum_d     = csum_q ^ word;
                        word_idx_d = idx_inc;
                        if ({{(32-IDX_W){1'b0}}, idx_inc} == count_q) begin
                            state_d = CHK;
                        end
                    end
                end
            end
            CHK: begin
                if (fire) begin
                    shift_d    = word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        if (word == csum_q) begin
                            state_d      = DONE;
                            done_d       = 1'b1;
                            core_reset_d = 1'b0;
                        end else begin
                            state_d = ERROR;
                            error_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = ready;
    assign done           = done_q;
    assign error          = error_q;
    assign core_reset     = core_reset_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    logic clk;
    logic reset;
    logic start;
    logic core_reset;
    logic busy;
    logic done;
    logic error;

    int checks;
    int errors;
    int wr_total;
    logic [31:0] wr_addr  [64];
    logic [31:0] wr_data  [64];

    logic [7:0] good [16];
    logic [7:0] bad  [16];
    int base;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial wr_total = 0;
    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr[wr_total % 64] = bus.imem_addr;
            wr_data[wr_total % 64] = bus.imem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s [16], input int n);
        for (int i = 0; i < n; i++) send_byte(s[i]);
    endtask

    task automatic check_two_writes(input string tag, input int b);
        check({tag, "_wr_cnt"}, 32'(wr_total - b), 32'd2);
        check({tag, "_addr0"}, wr_addr[b % 64], 32'h0);
        check({tag, "_data0"}, wr_data[b % 64], 32'h0050_0093);
        check({tag, "_addr1"}, wr_addr[(b + 1) % 64], 32'h4);
        check({tag, "_data1"}, wr_data[(b + 1) % 64], 32'h0010_0113);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        good = '{8'h02, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00,
                 8'h80, 8'h01, 8'h40, 8'h00};
        bad = good;
        for (int i = 12; i < 16; i++) bad[i] = 8'h00;

        start = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_wdata", bus.imem_wdata, 32'h0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Good load, back-to-back bytes
        base = wr_total;
        pulse_start();
        check("good_busy", 32'(busy), 32'd1);
        check("good_in_ready", 32'(bus.in_ready), 32'd1);
        send_stream(good, 15);
        check("good_done_early", 32'(done), 32'd0);
        check("good_core_reset_early", 32'(core_reset), 32'd1);
        send_byte(8'h00);
        check("good_done", 32'(done), 32'd1);
        check("good_core_reset", 32'(core_reset), 32'd0);
        check("good_error", 32'(error), 32'd0);
        check("good_busy_end", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_two_writes("good", base);
        check("good_addr_hold", bus.imem_addr, 32'h4);
        check("good_wdata_hold", bus.imem_wdata, 32'h0010_0113);

        // Bad checksum; restart from DONE must reassert core_reset
        base = wr_total;
        pulse_start();
        check("bad_core_reset_restart", 32'(core_reset), 32'd1);
        check("bad_done_cleared", 32'(done), 32'd0);
        send_stream(bad, 16);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_core_reset", 32'(core_reset), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_two_writes("bad", base);

        // Illegal counts: N=0 then N=65
        base = wr_total;
        pulse_start();
        check("n0_error_cleared", 32'(error), 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("n0_error", 32'(error), 32'd1);
        check("n0_in_ready", 32'(bus.in_ready), 32'd0);
        pulse_start();
        send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
        check("n65_error_early", 32'(error), 32'd0);
        send_byte(8'h00);
        check("n65_error", 32'(error), 32'd1);
        check("n65_in_ready", 32'(bus.in_ready), 32'd0);
        check("n65_core_reset", 32'(core_reset), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("illegal_wr_cnt", 32'(wr_total - base), 32'd0);

        // Stalled stream with a start pulse in the middle of DATA
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            if (i == 6) pulse_start();
            send_byte(good[i]);
        end
        check("stall_done", 32'(done), 32'd1);
        check("stall_error", 32'(error), 32'd0);
        check("stall_core_reset", 32'(core_reset), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_two_writes("stall", base);

        // Reset right after the first write, then a clean reload
        base = wr_total;
        pulse_start();
        send_stream(good, 8);
        check("mid_first_we", 32'(bus.imem_we), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_we", 32'(bus.imem_we), 32'd0);
        check("mid_rst_addr", bus.imem_addr, 32'h0);
        check("mid_rst_wdata", bus.imem_wdata, 32'h0);
        check("mid_rst_core_reset", 32'(core_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_wr_cnt", 32'(wr_total - base), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_idle_busy", 32'(busy), 32'd0);
        base = wr_total;
        pulse_start();
        send_stream(good, 16);
        check("reload_done", 32'(done), 32'd1);
        check("reload_core_reset", 32'(core_reset), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_two_writes("reload", base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
